// File: rtl/spi_mem_slave_fsm.sv
// spi_mem_slave_fsm: control sequencer for the SPI memory slave.
// Orders command, address, read and write phases and drives the datapath enables.
module spi_mem_slave_fsm #(
   parameter int ADDR_BITS    = 7,
   parameter int DATA_BITS    = 8,
   parameter int READ_LATENCY = 2,
   parameter int BURST_EN     = 1,
   localparam int CMD_BITS    = ADDR_BITS + 1,
   localparam int CNT_MAX     = (CMD_BITS > DATA_BITS) ? CMD_BITS : DATA_BITS,
   localparam int CNT_W       = $clog2(CNT_MAX + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sclk_pos,
   input  logic             cs,
   input  logic             read_write,
   output logic             miso_buff,
   output logic             dm_we,
   output logic             ad_we,
   output logic             sr_we,
   output logic             addr_inc,
   output logic             frame_err,
   output logic [3:0]       dbg_state_o,
   output logic [CNT_W-1:0] dbg_count_o
);

   typedef enum logic [3:0] {
      S_IDLE         = 4'd0,
      S_GET          = 4'd1,
      S_GOT          = 4'd2,
      S_READ_WAIT    = 4'd3,
      S_READ_LOAD    = 4'd4,
      S_READ_SHIFT   = 4'd5,
      S_READ_INC     = 4'd6,
      S_WRITE        = 4'd7,
      S_WRITE_COMMIT = 4'd8,
      S_DONE         = 4'd9
   } state_t;

   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
   localparam logic [3:0]       WAIT_LAST = 4'(READ_LATENCY - 1);
   localparam bit               BURST     = (BURST_EN != 0);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [3:0]       wait_q, wait_d;
   logic             frame_err_q, frame_err_d;
   logic             mid_frame;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         wait_q      <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         wait_q      <= wait_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin : next_state
      state_d     = state_q;
      count_d     = count_q;
      wait_d      = '0;
      frame_err_d = 1'b0;
      mid_frame   = 1'b0;

      // A frame counts as broken only once it has committed to partial work.
      unique case (state_q)
         S_GET, S_READ_SHIFT, S_WRITE:     mid_frame = (count_q != '0);
         S_GOT, S_READ_WAIT, S_READ_LOAD:  mid_frame = 1'b1;
         default:                          mid_frame = 1'b0;
      endcase

      if (cs) begin
         state_d     = S_IDLE;
         count_d     = '0;
         frame_err_d = mid_frame;
      end else begin
         unique case (state_q)
            S_IDLE: state_d = S_GET;
            S_GET: begin
               if (sclk_pos) begin
                  if (count_q == CMD_LAST) state_d = S_GOT;
                  else                     count_d = count_q + CNT_W'(1);
               end
            end
            S_GOT: begin
               if (read_write) state_d = S_READ_WAIT;
               else            state_d = S_WRITE;
            end
            S_READ_WAIT: begin
               if (wait_q == WAIT_LAST) state_d = S_READ_LOAD;
               else                     wait_d  = wait_q + 4'd1;
            end
            S_READ_LOAD: state_d = S_READ_SHIFT;
            S_READ_SHIFT: begin
               if (sclk_pos) begin
                  if (count_q == DATA_LAST) begin
                     if (BURST) state_d = S_READ_INC;
                     else       state_d = S_DONE;
                  end else begin
                     count_d = count_q + CNT_W'(1);
                  end
               end
            end
            S_READ_INC: state_d = S_READ_WAIT;
            S_WRITE: begin
               if (sclk_pos) begin
                  if (count_q == DATA_LAST) state_d = S_WRITE_COMMIT;
                  else                      count_d = count_q + CNT_W'(1);
               end
            end
            S_WRITE_COMMIT: begin
               if (BURST) state_d = S_WRITE;
               else       state_d = S_DONE;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
         if (state_d != state_q) count_d = '0;
      end
   end

   always_comb begin : outputs
      miso_buff = 1'b0;
      dm_we     = 1'b0;
      ad_we     = 1'b0;
      sr_we     = 1'b0;
      addr_inc  = 1'b0;
      unique case (state_q)
         S_GOT:          ad_we     = 1'b1;
         S_READ_LOAD:    sr_we     = 1'b1;
         S_READ_SHIFT:   miso_buff = 1'b1;
         S_READ_INC:     addr_inc  = 1'b1;
         // Memory still sees the pre-increment address during this cycle.
         S_WRITE_COMMIT: begin
            dm_we    = 1'b1;
            addr_inc = BURST;
         end
         default: ;
      endcase
      frame_err = frame_err_q;
   end

   assign dbg_state_o = state_q;
   assign dbg_count_o = count_q;

endmodule

// File: tb/tb_spi_mem_slave_fsm.sv
// tb_spi_mem_slave_fsm: randomized frames for a single-word and a burst controller,
// expected enable events queued per frame and matched by an output monitor.
module tb_spi_mem_slave_fsm;

   localparam int RL = 2;
   localparam logic [5:0] V_MISO = 6'b000001;
   localparam logic [5:0] V_DM   = 6'b000010;
   localparam logic [5:0] V_AD   = 6'b000100;
   localparam logic [5:0] V_SR   = 6'b001000;
   localparam logic [5:0] V_INC  = 6'b010000;
   localparam logic [5:0] V_ERR  = 6'b100000;

   logic       clk = 1'b0;
   logic [1:0] reset, sclk_pos, cs, read_write;
   logic [1:0] miso_buff, dm_we, ad_we, sr_we, addr_inc, frame_err;
   logic [3:0] dbg_state [2];
   logic [3:0] dbg_count [2];

   int          edge_n = 0;
   int          checks = 0;
   int          errors = 0;
   int          nxt;
   logic [31:0] exp_q[$];
   logic [3:0]  tk_q[$];

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   spi_mem_slave_fsm #(.ADDR_BITS(7), .DATA_BITS(8), .READ_LATENCY(RL), .BURST_EN(0)) dut0 (
      .clk(clk), .reset(reset[0]), .sclk_pos(sclk_pos[0]), .cs(cs[0]),
      .read_write(read_write[0]), .miso_buff(miso_buff[0]), .dm_we(dm_we[0]),
      .ad_we(ad_we[0]), .sr_we(sr_we[0]), .addr_inc(addr_inc[0]),
      .frame_err(frame_err[0]), .dbg_state_o(dbg_state[0]), .dbg_count_o(dbg_count[0])
   );

   spi_mem_slave_fsm #(.ADDR_BITS(7), .DATA_BITS(8), .READ_LATENCY(RL), .BURST_EN(1)) dut1 (
      .clk(clk), .reset(reset[1]), .sclk_pos(sclk_pos[1]), .cs(cs[1]),
      .read_write(read_write[1]), .miso_buff(miso_buff[1]), .dm_we(dm_we[1]),
      .ad_we(ad_we[1]), .sr_we(sr_we[1]), .addr_inc(addr_inc[1]),
      .frame_err(frame_err[1]), .dbg_state_o(dbg_state[1]), .dbg_count_o(dbg_count[1])
   );

   function automatic logic [5:0] out_vec(input int d);
      return {frame_err[d], addr_inc[d], sr_we[d], ad_we[d], dm_we[d], miso_buff[d]};
   endfunction

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // scoreboard monitor
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         logic [5:0]  v;
         logic [31:0] e;
         v = out_vec(d);
         if (v != 6'd0) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event dut=%0d edge=%0d got=%b expected none", d, edge_n, v);
            end else begin
               e = exp_q.pop_front();
               if (int'(e[31]) != d || int'(e[30:6]) != edge_n || e[5:0] != v) begin
                  errors++;
                  $display("FAIL event dut=%0d got=%b@%0d expected dut=%0d %b@%0d",
                           d, v, edge_n, e[31], e[5:0], int'(e[30:6]));
               end
            end
         end
      end
      while (exp_q.size() > 0 && int'(exp_q[0][30:6]) < edge_n) begin
         checks++;
         errors++;
         $display("FAIL missing_event dut=%0d expected=%b@%0d got none", exp_q[0][31],
                  exp_q[0][5:0], int'(exp_q[0][30:6]));
         void'(exp_q.pop_front());
      end
   end

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   // driver tasks
   task automatic push_ev(input int d, input int e, input logic [5:0] v);
      exp_q.push_back({1'(d), 25'(e), v});
   endtask

   task automatic add(input bit c, input bit s, input bit r, input bit rs);
      tk_q.push_back({rs, r, s, c});
      nxt++;
   endtask

   task automatic idle(input int n);
      repeat (n) add(1'b0, 1'b0, rb(), 1'b0);
   endtask

   task automatic play(input int d);
      logic [3:0] t;
      while (tk_q.size() > 0) begin
         t = tk_q.pop_front();
         cs = 2'b11; sclk_pos = 2'b00; read_write = 2'b00; reset = 2'b00;
         cs[d] = t[0]; sclk_pos[d] = t[1]; read_write[d] = t[2]; reset[d] = t[3];
         @(posedge clk); #1;
      end
      cs = 2'b11; sclk_pos = 2'b00; reset = 2'b00;
   endtask

   // ab: 0 none, 1 write-data abort, 2 cs with 8th cmd strobe, 3 reset mid-read, 4 cs in read wait
   task automatic frame(input int d, input bit is_rd, input int nw, input int ab);
      int k, m, ref_e, jab, e0;
      bit burst;
      burst = (d == 1);
      nxt   = edge_n + 1;
      jab   = $urandom_range(1, 7);
      add(1'b0, rb(), rb(), 1'b0);
      for (int i = 1; i <= 8; i++) begin
         idle($urandom_range(0, 2));
         if (i == 8 && ab == 2) begin
            add(1'b1, 1'b1, rb(), 1'b0);
            push_ev(d, nxt - 1, V_ERR);
            add(1'b1, 1'b0, rb(), 1'b0);
            play(d);
            return;
         end
         add(1'b0, 1'b1, rb(), 1'b0);
      end
      k = nxt - 1;
      push_ev(d, k, V_AD);
      if (ab == 4) begin
         add(1'b0, 1'b0, 1'b1, 1'b0);
         idle($urandom_range(0, RL - 1));
         add(1'b1, 1'b0, rb(), 1'b0);
         push_ev(d, nxt - 1, V_ERR);
         add(1'b1, 1'b0, rb(), 1'b0);
         play(d);
         return;
      end
      ref_e = k;
      for (int w = 0; w < nw; w++) begin
         add(1'b0, 1'b0, (w == 0) ? is_rd : rb(), 1'b0);
         if (is_rd) begin
            idle(RL + 1 + $urandom_range(0, 2));
            push_ev(d, ref_e + RL + 1, V_SR);
            e0 = ref_e + RL + 2;
         end else begin
            idle($urandom_range(0, 2));
            e0 = 0;
         end
         for (int i = 1; i <= 8; i++) begin
            if (i > 1) idle($urandom_range(0, 2));
            if (!is_rd && ab == 1 && w == nw - 1 && i == jab + 1) begin
               add(1'b1, rb(), rb(), 1'b0);
               push_ev(d, nxt - 1, V_ERR);
               add(1'b1, 1'b0, rb(), 1'b0);
               play(d);
               return;
            end
            if (is_rd && ab == 3 && w == 0 && i == jab + 1) begin
               add(1'b0, rb(), rb(), 1'b1);
               for (int c = e0; c < nxt - 1; c++) push_ev(d, c, V_MISO);
               add(1'b1, 1'b0, rb(), 1'b0);
               play(d);
               return;
            end
            add(1'b0, 1'b1, rb(), 1'b0);
         end
         m = nxt - 1;
         if (is_rd) begin
            for (int c = e0; c < m; c++) push_ev(d, c, V_MISO);
            if (burst) push_ev(d, m, V_INC);
         end else begin
            push_ev(d, m, burst ? (V_DM | V_INC) : V_DM);
         end
         ref_e = m;
      end
      // Single-word controller parks in DONE; further strobes must do nothing.
      if (!burst) begin
         for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, 2));
            add(1'b0, 1'b1, rb(), 1'b0);
         end
      end
      add(1'b1, 1'b0, rb(), 1'b0);
      add(1'b1, 1'b0, rb(), 1'b0);
      play(d);
   endtask

   task automatic rand_frame(input int d);
      bit is_rd;
      int nw, r, ab;
      is_rd = rb();
      nw    = (d == 1) ? $urandom_range(1, 3) : 1;
      r     = $urandom_range(0, 5);
      ab    = 0;
      if (r == 3) ab = is_rd ? 3 : 1;
      if (r == 4) ab = is_rd ? 4 : 2;
      if (r == 5) ab = 2;
      frame(d, is_rd, nw, ab);
   endtask

   initial begin
      reset = 2'b11; cs = 2'b00; read_write = 2'b00; sclk_pos = 2'b11;
      @(posedge clk); #1;
      sclk_pos = 2'b00;
      @(posedge clk); #1;
      @(negedge clk);
      check("reset_outputs_dut0", int'(out_vec(0)), 0);
      check("reset_outputs_dut1", int'(out_vec(1)), 0);
      check("reset_count_dut0", int'(dbg_count[0]), 0);
      reset = 2'b00; sclk_pos = 2'b11;
      @(posedge clk); #1;
      @(negedge clk);
      check("release_count_dut0", int'(dbg_count[0]), 0);
      check("release_count_dut1", int'(dbg_count[1]), 0);
      check("release_outputs_dut0", int'(out_vec(0)), 0);
      cs = 2'b11; sclk_pos = 2'b00;
      @(posedge clk); #1;
      @(posedge clk); #1;

      frame(0, 1'b0, 1, 0);
      frame(0, 1'b1, 1, 0);
      frame(0, 1'b0, 1, 1);
      frame(0, 1'b0, 1, 0);
      frame(0, 1'b0, 1, 2);
      frame(0, 1'b1, 1, 3);
      frame(0, 1'b1, 1, 4);
      frame(0, 1'b1, 1, 0);
      repeat (25) rand_frame(0);

      frame(1, 1'b0, 3, 0);
      frame(1, 1'b1, 3, 0);
      frame(1, 1'b0, 3, 1);
      frame(1, 1'b1, 1, 3);
      frame(1, 1'b0, 1, 0);
      repeat (25) rand_frame(1);

      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
